// File: rtl/frame_renderer_if.sv
// Purpose : Bundles the frame renderer's strobe, player/colour inputs and
//           frame-buffer write outputs into one port.
// Ports   : frame_start, p1/p2 position and colour, bg_color in;
//           addr_write, data_write, busy, done, overrun out.
//           master = renderer side, slave = producer/frame-buffer side.
interface frame_renderer_if;
  logic        frame_start;
  logic [6:0]  p1_x;
  logic [6:0]  p1_y;
  logic [6:0]  p2_x;
  logic [6:0]  p2_y;
  logic [7:0]  p1_color;
  logic [7:0]  p2_color;
  logic [7:0]  bg_color;
  logic [13:0] addr_write;
  logic [7:0]  data_write;
  logic        busy;
  logic        done;
  logic        overrun;

  modport master (
    input  frame_start, p1_x, p1_y, p2_x, p2_y, p1_color, p2_color, bg_color,
    output addr_write, data_write, busy, done, overrun
  );

  modport slave (
    output frame_start, p1_x, p1_y, p2_x, p2_y, p1_color, p2_color, bg_color,
    input  addr_write, data_write, busy, done, overrun
  );
endinterface

// File: rtl/frame_renderer.sv
// Purpose : Sweeps the 128x96 framebuffer in raster order on each frame_start,
//           composing background, two player rectangles and optional floor.
// Latency : pixel k appears k+1 cycles after the strobe edge; done 12289 after.
// Backpressure: none; one write per cycle, a strobe while drawing restarts
//           the sweep and sets the sticky overrun flag.
// Ports   : clk, reset_n (synchronous, active-low), bus (frame_renderer_if.master).
// Config  : define FLOOR_EN to paint rows >= FLOOR_Y with FLOOR_COLOR.
module frame_renderer #(
  parameter int SPRITE_W = 8,
  parameter int SPRITE_H = 16
`ifdef FLOOR_EN
  ,
  parameter int         FLOOR_Y     = 80,
  parameter logic [7:0] FLOOR_COLOR = 8'h24
`endif
) (
  input  logic               clk,
  input  logic               reset_n,
  frame_renderer_if.master   bus
);

  typedef enum logic {IDLE, DRAW} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        emit;
  logic        restart;

  logic [6:0]  x;
  logic [6:0]  y;
  logic [6:0]  s_p1_x, s_p1_y, s_p2_x, s_p2_y;
  logic [7:0]  s_p1_color, s_p2_color, s_bg_color;
  logic [7:0]  pix;
  logic        hit1, hit2;
  logic        last_px;

  logic [13:0] addr_q;
  logic [7:0]  data_q;
  logic        busy_q, done_q, overrun_q;

  assign last_px = (x == 7'd127) && (y == 7'd95);

  // Right/bottom bounds are formed at 8 bits so a sprite near the edge
  // clips instead of wrapping back to column/row 0.
  function automatic logic hit(input logic [6:0] px, input logic [6:0] py,
                               input logic [6:0] cx, input logic [6:0] cy);
    logic [7:0] x_end;
    logic [7:0] y_end;
    x_end = {1'b0, px} + 8'(SPRITE_W);
    y_end = {1'b0, py} + 8'(SPRITE_H);
    return (cx >= px) && ({1'b0, cx} < x_end) &&
           (cy >= py) && ({1'b0, cy} < y_end);
  endfunction

  assign hit1 = hit(s_p1_x, s_p1_y, x, y);
  assign hit2 = hit(s_p2_x, s_p2_y, x, y);

  // Priority p1 > p2 > floor > background: later assignments win.
  always_comb begin
    pix = s_bg_color;
`ifdef FLOOR_EN
    if (y >= 7'(FLOOR_Y)) pix = FLOOR_COLOR;
`endif
    if (hit2) pix = s_p2_color;
    if (hit1) pix = s_p1_color;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; a strobe on the final pixel keeps us in DRAW (restart).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.frame_start) state_nxt = DRAW;
      DRAW:    if (!bus.frame_start && last_px) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    emit    = 1'b0;
    restart = 1'b0;
    case (state)
      DRAW: begin
        emit    = 1'b1;
        restart = bus.frame_start;
      end
      default: begin
        emit    = 1'b0;
        restart = 1'b0;
      end
    endcase
  end

  // Datapath: counters, shadow registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x          <= '0;
      y          <= '0;
      s_p1_x     <= '0;
      s_p1_y     <= '0;
      s_p2_x     <= '0;
      s_p2_y     <= '0;
      s_p1_color <= '0;
      s_p2_color <= '0;
      s_bg_color <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      // busy trails the state by one cycle to line up with the registered
      // pixel; its falling edge marks a sweep that ran to completion.
      busy_q <= (state == DRAW);
      done_q <= busy_q && (state == IDLE);

      if (emit) begin
        addr_q <= {y, x};
        data_q <= pix;
        x      <= x + 7'd1;
        if (x == 7'd127) y <= y + 7'd1;
      end

      // Placed after the increment so a restart's counter clear wins.
      if (bus.frame_start) begin
        x          <= '0;
        y          <= '0;
        s_p1_x     <= bus.p1_x;
        s_p1_y     <= bus.p1_y;
        s_p2_x     <= bus.p2_x;
        s_p2_y     <= bus.p2_y;
        s_p1_color <= bus.p1_color;
        s_p2_color <= bus.p2_color;
        s_bg_color <= bus.bg_color;
      end

      if (restart) overrun_q <= 1'b1;
    end
  end

  assign bus.addr_write = addr_q;
  assign bus.data_write = data_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_frame_renderer.sv
// Purpose : Self-checking bench for frame_renderer: cycle-level model of the
//           sweep timing plus literal pixel/timing checks per scenario.
// Ports   : none (top-level bench); drives the DUT through frame_renderer_if.
module tb_frame_renderer;
  localparam int NPIX = 12288;
  localparam int NONE = -1000000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  frame_renderer_if bus();

  frame_renderer #(.SPRITE_W(8), .SPRITE_H(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model state: cycle of the accepted strobe plus its latched inputs.
  int         m_start = NONE;
  int         m_d;
  int         m_p1x, m_p1y, m_p2x, m_p2y;
  logic [7:0] m_c1, m_c2, m_bg;
  int         m_addr = 0;
  logic [7:0] m_data = 8'h00;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic       m_ovr  = 1'b0;

  logic [7:0] cap [NPIX];

  function automatic logic [7:0] model_pixel(input int k);
    int px, py;
    px = k % 128;
    py = k / 128;
    if (px >= m_p1x && px < m_p1x + 8 && py >= m_p1y && py < m_p1y + 16) return m_c1;
    if (px >= m_p2x && px < m_p2x + 8 && py >= m_p2y && py < m_p2y + 16) return m_c2;
`ifdef FLOOR_EN
    if (py >= 80) return 8'h24;
`endif
    return m_bg;
  endfunction

  // Edge c after a strobe at edge N: pixel c-N-1 shown for c-N in 1..NPIX,
  // done exactly at N+NPIX+1; a strobe inside that window is an overrun.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!reset_n) begin
      m_start = NONE;
      m_addr  = 0;
      m_data  = 8'h00;
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      m_d    = cyc - m_start;
      m_busy = (m_d >= 1 && m_d <= NPIX);
      m_done = (m_d == NPIX + 1);
      if (m_busy) begin
        m_addr = m_d - 1;
        m_data = model_pixel(m_d - 1);
      end
      if (bus.frame_start) begin
        if (m_busy) m_ovr = 1'b1;
        m_start = cyc;
        m_p1x = int'(bus.p1_x);
        m_p1y = int'(bus.p1_y);
        m_p2x = int'(bus.p2_x);
        m_p2y = int'(bus.p2_y);
        m_c1  = bus.p1_color;
        m_c2  = bus.p2_color;
        m_bg  = bus.bg_color;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      vectors = vectors + 1;
      if (bus.addr_write !== 14'(m_addr) || bus.data_write !== m_data ||
          bus.busy !== m_busy || bus.done !== m_done || bus.overrun !== m_ovr) begin
        miscompares = miscompares + 1;
        $display("FAIL cycle_%0d outputs: got addr=%0d data=%02h busy=%b done=%b ovr=%b, want addr=%0d data=%02h busy=%b done=%b ovr=%b",
                 cyc, bus.addr_write, bus.data_write, bus.busy, bus.done, bus.overrun,
                 m_addr, m_data, m_busy, m_done, m_ovr);
      end
      if (bus.busy === 1'b1 && bus.addr_write < 14'(NPIX))
        cap[bus.addr_write] = bus.data_write;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors = vectors + 1;
    if (act != exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic strobe(output int edge_at);
    @(posedge clk);
    #1 bus.frame_start = 1'b1;
    @(posedge clk);
    #1 bus.frame_start = 1'b0;
    edge_at = cyc;
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic clear_cap();
    for (int i = 0; i < NPIX; i++) cap[i] = 8'h00;
  endtask

  initial begin
    #1_000_000;
    miscompares = miscompares + 1;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    int t0, t1, done_at, bad, dones;
    bus.frame_start = 1'b0;
    bus.p1_x = 7'd0;   bus.p1_y = 7'd127;
    bus.p2_x = 7'd0;   bus.p2_y = 7'd127;
    bus.p1_color = 8'h00;
    bus.p2_color = 8'h00;
    bus.bg_color = 8'h00;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset values, then idle hold
    @(negedge clk);
    chk("rst_addr", int'(bus.addr_write), 0);
    chk("rst_data", int'(bus.data_write), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_overrun", int'(bus.overrun), 0);
    repeat (5) @(negedge clk);
    chk("idle_busy", int'(bus.busy), 0);
    chk("idle_addr", int'(bus.addr_write), 0);

    // Background-only sweep
    bus.bg_color = 8'h11;
    clear_cap();
    strobe(t0);
    wait_done(13000, done_at);
    chk("bg_done_latency", done_at - t0, 12289);
    chk("bg_busy_at_done", int'(bus.busy), 0);
    bad = 0;
    for (int i = 0; i < NPIX; i++) begin
`ifdef FLOOR_EN
      if (cap[i] != ((i / 128 >= 80) ? 8'h24 : 8'h11)) bad++;
`else
      if (cap[i] != 8'h11) bad++;
`endif
    end
    chk("bg_bad_pixels", bad, 0);
    @(negedge clk);
    chk("bg_done_one_cycle", int'(bus.done), 0);

    // Priority
    bus.p1_x = 7'd10; bus.p1_y = 7'd10; bus.p1_color = 8'hE0;
    bus.p2_x = 7'd14; bus.p2_y = 7'd12; bus.p2_color = 8'h1C;
    clear_cap();
    strobe(t0);
    wait_done(13000, done_at);
    chk("prio_done_latency", done_at - t0, 12289);
    chk("prio_1290", int'(cap[1290]), 'hE0);
    chk("prio_1550", int'(cap[1550]), 'hE0);
    chk("prio_1556", int'(cap[1556]), 'h1C);
    chk("prio_1558", int'(cap[1558]), 'h11);

    // Edge clipping, with p1 changed mid-sweep (must not affect this frame)
    bus.p1_x = 7'd124; bus.p1_y = 7'd90; bus.p1_color = 8'hAA;
    bus.p2_y = 7'd127;
    clear_cap();
    strobe(t0);
    repeat (100) @(posedge clk);
    #1 bus.p1_x = 7'd0;
    bus.p1_color = 8'h55;
    wait_done(13000, done_at);
    chk("clip_done_latency", done_at - t0, 12289);
    chk("clip_11644", int'(cap[11644]), 'hAA);
    chk("clip_12287", int'(cap[12287]), 'hAA);
    chk("clip_11643", int'(cap[11643]), 'hAA - 'hAA + 'h11 + 0);
`ifdef FLOOR_EN
    chk("clip_11648", int'(cap[11648]), 'h24);
    chk("clip_11651", int'(cap[11651]), 'h24);
`else
    chk("clip_11648", int'(cap[11648]), 'h11);
    chk("clip_11651", int'(cap[11651]), 'h11);
`endif
    chk("clip_0", int'(cap[0]), 'h11);

    // Restart while busy -> overrun, single done
    bus.p1_x = 7'd10; bus.p1_y = 7'd10; bus.p1_color = 8'hE0;
    @(negedge clk);
    chk("ovr_before", int'(bus.overrun), 0);
    strobe(t0);
    repeat (4999) @(posedge clk);
    #1 bus.frame_start = 1'b1;
    @(posedge clk);
    #1 bus.frame_start = 1'b0;
    t1 = cyc;
    chk("ovr_restart_edge", t1 - t0, 5000);
    @(posedge clk);
    @(negedge clk);
    chk("ovr_addr0", int'(bus.addr_write), 0);
    chk("ovr_data0", int'(bus.data_write), 'h11);
    chk("ovr_busy", int'(bus.busy), 1);
    chk("ovr_flag", int'(bus.overrun), 1);
    dones = 0;
    done_at = -1;
    for (int i = 0; i < 12400; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        dones++;
        done_at = cyc;
      end
    end
    chk("ovr_done_count", dones, 1);
    chk("ovr_done_latency", done_at - t1, 12289);

    // Reset mid-sweep clears everything, including overrun
    strobe(t0);
    repeat (50) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("mrst_addr", int'(bus.addr_write), 0);
    chk("mrst_data", int'(bus.data_write), 0);
    chk("mrst_busy", int'(bus.busy), 0);
    chk("mrst_overrun", int'(bus.overrun), 0);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    chk("mrst_stays_idle", dones, 0);

`ifdef FLOOR_EN
    // Floor
    bus.p1_y = 7'd127;
    bus.p2_x = 7'd0; bus.p2_y = 7'd85; bus.p2_color = 8'hC3;
    bus.bg_color = 8'h11;
    clear_cap();
    strobe(t0);
    wait_done(13000, done_at);
    chk("floor_done_latency", done_at - t0, 12289);
    chk("floor_10280", int'(cap[10280]), 'h24);
    chk("floor_10880", int'(cap[10880]), 'hC3);
    chk("floor_10152", int'(cap[10152]), 'h11);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
